// File: rtl/nn_feeder_pkg.sv
// Shared types and defaults for the nn pixel feeder.
// Used by nn_pixel_feeder_if, nn_frame_ram and nn_pixel_feeder.
package nn_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        HI,
        LO,
        DONE
    } feeder_state_e;

    localparam int DEF_BITS        = 24;
    localparam int DEF_WIDTH       = 784;
    localparam int IDX_W           = $clog2(DEF_WIDTH);
    localparam int DEF_STROBE_HIGH = 2;
    localparam int DEF_STROBE_LOW  = 3;

endpackage

// File: rtl/nn_pixel_feeder_if.sv
// Host/receiver-facing signal bundle of the pixel feeder.
// The master modport is the host side; the slave modport is the feeder.
// Optional abort/aborted signals exist only when NN_FEEDER_ABORT_EN is defined.
interface nn_pixel_feeder_if
    import nn_feeder_pkg::*;
#(
    parameter int BITS  = DEF_BITS,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int IW = $clog2(WIDTH);

    logic            wr_en;
    logic [IW-1:0]   wr_addr;
    logic [BITS-1:0] wr_data;
    logic            start;
    logic [BITS-1:0] pixel_out;
    logic            new_data;
    logic [IW-1:0]   pix_idx;
    logic            busy;
    logic            done;
    logic            wr_err;
`ifdef NN_FEEDER_ABORT_EN
    logic            abort;
    logic            aborted;

    modport master (
        output wr_en, wr_addr, wr_data, start, abort,
        input  pixel_out, new_data, pix_idx, busy, done, wr_err, aborted
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, abort,
        output pixel_out, new_data, pix_idx, busy, done, wr_err, aborted
    );
`else
    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  pixel_out, new_data, pix_idx, busy, done, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output pixel_out, new_data, pix_idx, busy, done, wr_err
    );
`endif

endinterface

// File: rtl/nn_frame_ram.sv
// Frame buffer: WIDTH x BITS simple dual-port memory with a synchronous,
// enable-gated read register that doubles as the feeder's pixel_out hold
// register. Write-first on a same-cycle address collision.
module nn_frame_ram
    import nn_feeder_pkg::*;
#(
    parameter int BITS  = DEF_BITS,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_addr,
    input  logic [BITS-1:0] wr_data,
    input  logic            rd_en,
    input  logic [IW-1:0]   rd_addr,
    output logic [BITS-1:0] rd_data
);

    logic [BITS-1:0] mem [WIDTH];

    // Storage array: contents are never reset so a frame survives reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register: loads only on rd_en and otherwise holds its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/nn_pixel_feeder.sv
// Streams one stored 28x28 frame into nn over the pixel/new_data interface.
// Each pixel takes 2+STROBE_HIGH+STROBE_LOW cycles: FETCH, SETUP, HI, LO,
// which suits the receiver's 3-flop rising-edge synchronizer.
// Optional feature macro: NN_FEEDER_ABORT_EN (adds abort/aborted).
module nn_pixel_feeder
    import nn_feeder_pkg::*;
#(
    parameter int BITS        = DEF_BITS,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int STROBE_HIGH = DEF_STROBE_HIGH,
    parameter int STROBE_LOW  = DEF_STROBE_LOW
) (
    input logic               clk,
    input logic               reset,
    nn_pixel_feeder_if.slave  bus
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(STROBE_HIGH + STROBE_LOW);

    if (STROBE_HIGH < 2) begin : g_bad_strobe_high
        $error("nn_pixel_feeder: STROBE_HIGH must be >= 2");
    end
    if (STROBE_LOW < 2) begin : g_bad_strobe_low
        $error("nn_pixel_feeder: STROBE_LOW must be >= 2");
    end

    feeder_state_e   state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic            rd_en;
    logic            active;
    logic            wr_ok;
    logic            wr_bad;
    logic            new_data_r;
    logic            busy_r;
    logic            done_r;
    logic            wr_err_r;
    logic [BITS-1:0] pix;
`ifdef NN_FEEDER_ABORT_EN
    logic            abort_take;
    logic            aborted_r;
`endif

    assign active = (state == FETCH) || (state == SETUP) || (state == HI) || (state == LO);

    // Writes are only legal while idle and inside the frame.
    assign wr_bad = bus.wr_en && (active || (int'(bus.wr_addr) >= WIDTH));
    assign wr_ok  = bus.wr_en && !wr_bad;

    // Next-state logic: pixel sequencing and strobe phase counting.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        rd_en     = 1'b0;
`ifdef NN_FEEDER_ABORT_EN
        abort_take = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = FETCH;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            FETCH: begin
                rd_en     = 1'b1;
                state_nxt = SETUP;
            end
            SETUP: begin
                state_nxt = HI;
                cnt_nxt   = '0;
            end
            HI: begin
                if (cnt == CW'(STROBE_HIGH - 1)) begin
                    state_nxt = LO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LO: begin
                if (cnt == CW'(STROBE_LOW - 1)) begin
                    cnt_nxt = '0;
                    if (idx == IW'(WIDTH - 1)) begin
                        state_nxt = DONE;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = FETCH;
                        idx_nxt   = idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
`ifdef NN_FEEDER_ABORT_EN
        if (bus.abort && active) begin
            state_nxt  = IDLE;
            idx_nxt    = '0;
            cnt_nxt    = '0;
            rd_en      = 1'b0;
            abort_take = 1'b1;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters and registered outputs, all derived from the next state so
    // they change on the same edge as the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            new_data_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            wr_err_r   <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            new_data_r <= (state_nxt == HI);
            busy_r     <= (state_nxt == FETCH) || (state_nxt == SETUP) ||
                          (state_nxt == HI) || (state_nxt == LO);
            done_r     <= (state_nxt == DONE);
            wr_err_r   <= wr_bad;
        end
    end

`ifdef NN_FEEDER_ABORT_EN
    // One-cycle acknowledge of an accepted abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aborted_r <= 1'b0;
        end else begin
            aborted_r <= abort_take;
        end
    end

    assign bus.aborted = aborted_r;
`endif

    nn_frame_ram #(
        .BITS  (BITS),
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_ram (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (wr_ok),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en),
        .rd_addr (idx),
        .rd_data (pix)
    );

    assign bus.pixel_out = pix;
    assign bus.new_data  = new_data_r;
    assign bus.pix_idx   = idx;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.wr_err    = wr_err_r;

endmodule

// File: tb/tb_nn_pixel_feeder.sv
// Testbench for nn_pixel_feeder: random and counting frame contents,
// cycle-by-cycle comparison against a timeline model derived from the
// pixel period, plus a receiver synchronizer model capturing each pixel.
module tb_nn_pixel_feeder;
    import nn_feeder_pkg::*;

    localparam int BITS  = 24;
    localparam int WIDTH = 784;
    localparam int SH    = 2;
    localparam int SL    = 3;
    localparam int P     = 2 + SH + SL;
    localparam int FRAME = WIDTH * P;
    localparam int IW    = $clog2(WIDTH);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    nn_pixel_feeder_if #(.BITS(BITS), .WIDTH(WIDTH)) bus ();

    nn_pixel_feeder #(
        .BITS        (BITS),
        .WIDTH       (WIDTH),
        .STROBE_HIGH (SH),
        .STROBE_LOW  (SL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [BITS-1:0] mem_model [WIDTH];
    logic [BITS-1:0] last_pix = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [BITS-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = IW'(addr);
        bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
        if (addr < WIDTH) mem_model[addr] = d;
    endtask

    task automatic load_frame(input bit rnd);
        for (int i = 0; i < WIDTH; i++) begin
            wr(i, rnd ? BITS'($urandom) : BITS'(i + 1));
        end
        check("load_wr_err", 32'(bus.wr_err), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_pixel_out"}, 32'(bus.pixel_out), 32'd0);
        check({tag, "_new_data"}, 32'(bus.new_data), 32'd0);
        check({tag, "_pix_idx"}, 32'(bus.pix_idx), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_wr_err"}, 32'(bus.wr_err), 32'd0);
    endtask

    // Streams one frame from IDLE. Optional events (time t counts edges
    // after the accepted start): reset_t, abort_t, a rejected write at bwr_t,
    // an ignored start at bstart_t, and a write to address 0 alongside start.
    task automatic run_frame(input int reset_t, input int abort_t, input int bwr_t,
                             input int bstart_t, input bit same_wr);
        int dones = 0;
        int rises = 0;
        int ens   = 0;
        logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, prev_nd = 1'b0;
        int i, ph;
        logic e_nd, e_busy, e_done;
        logic [IW-1:0] e_idx;
        logic [BITS-1:0] e_pix;

        if (same_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = '0;
            bus.wr_data = BITS'($urandom);
            mem_model[0] = bus.wr_data;
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;

        for (int t = 0; t <= FRAME + 1; t++) begin
            if (t < FRAME) begin
                i      = t / P;
                ph     = t % P;
                e_nd   = (ph >= 2) && (ph < 2 + SH);
                e_busy = 1'b1;
                e_done = 1'b0;
                e_idx  = IW'(i);
                e_pix  = (ph == 0) ? ((i == 0) ? last_pix : mem_model[i-1]) : mem_model[i];
            end else begin
                e_nd   = 1'b0;
                e_busy = 1'b0;
                e_done = (t == FRAME);
                e_idx  = '0;
                e_pix  = mem_model[WIDTH-1];
            end
            check("new_data", 32'(bus.new_data), 32'(e_nd));
            check("busy", 32'(bus.busy), 32'(e_busy));
            check("done", 32'(bus.done), 32'(e_done));
            check("pix_idx", 32'(bus.pix_idx), 32'(e_idx));
            check("pixel_out", 32'(bus.pixel_out), 32'(e_pix));
            check("wr_err", 32'(bus.wr_err), 32'((bwr_t >= 0) && (t == bwr_t + 1)));
`ifdef NN_FEEDER_ABORT_EN
            check("aborted", 32'(bus.aborted), 32'd0);
`endif

            s3 = s2;
            s2 = s1;
            s1 = bus.new_data;
            if (s2 && !s3) begin
                if (ens < WIDTH) check("rx_pixel", 32'(bus.pixel_out), 32'(mem_model[ens]));
                ens++;
            end
            if (bus.new_data && !prev_nd) rises++;
            prev_nd = bus.new_data;
            if (bus.done) dones++;

            if (t == reset_t) begin
                #2 reset = 1'b1;
                #1;
                check_quiet("async_reset");
                @(negedge clk);
                reset = 1'b0;
                last_pix = '0;
                return;
            end

            if (t == abort_t) begin
`ifdef NN_FEEDER_ABORT_EN
                bus.abort = 1'b1;
                step();
                bus.abort = 1'b0;
                check("abort_new_data", 32'(bus.new_data), 32'd0);
                check("abort_aborted", 32'(bus.aborted), 32'd1);
                check("abort_busy", 32'(bus.busy), 32'd0);
                check("abort_pix_idx", 32'(bus.pix_idx), 32'd0);
                check("abort_done", 32'(bus.done), 32'd0);
                step();
                check("abort_aborted_end", 32'(bus.aborted), 32'd0);
                check("abort_done_end", 32'(bus.done), 32'd0);
                check("abort_busy_end", 32'(bus.busy), 32'd0);
                last_pix = mem_model[t / P];
                return;
`endif
            end

            bus.wr_en = (t == bwr_t);
            if (t == bwr_t) begin
                bus.wr_addr = IW'(5);
                bus.wr_data = 24'hABCDEF;
            end
            bus.start = (t == bstart_t);
            step();
        end
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        check("done_count", 32'(dones), 32'd1);
        check("strobe_rises", 32'(rises), 32'(WIDTH));
        check("rx_en_count", 32'(ens), 32'(WIDTH));
        last_pix = mem_model[WIDTH-1];
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
`ifdef NN_FEEDER_ABORT_EN
        bus.abort   = 1'b0;
`endif
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset_state");
        @(negedge clk);
        reset = 1'b0;
        step();

        // Counting pattern with a rejected write and an ignored start mid-frame.
        load_frame(1'b0);
        run_frame(-1, -1, 50, 200, 1'b0);

        // Out-of-range write while idle.
        wr(800, 24'h123456);
        check("oor_wr_err", 32'(bus.wr_err), 32'd1);
        step();
        check("oor_wr_err_clear", 32'(bus.wr_err), 32'd0);

        // Reset in the middle of pixel 100, then a full frame from pixel 0.
        run_frame(100 * P + 3, -1, -1, -1, 1'b0);
        run_frame(-1, -1, -1, -1, 1'b0);

        // Random contents, with a write to address 0 in the start cycle.
        load_frame(1'b1);
        run_frame(-1, -1, -1, -1, 1'b1);

`ifdef NN_FEEDER_ABORT_EN
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("idle_abort_ignored", 32'(bus.aborted), 32'd0);
        run_frame(-1, 10 * P + 2, -1, -1, 1'b0);
        run_frame(-1, -1, -1, -1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
